// File: rtl/mac_mii_top.sv
// Ethernet MAC transmit frame generator: preamble/SFD, header, padded payload and
// CRC-32 FCS on a 64-bit, 8-lane MII/XGMII-style data path, then a 2-word IFG.
module mac_mii_top #(
  parameter int unsigned PAYLOAD_LENGTH   = 50,
  parameter int unsigned PAYLOAD_MAX_SIZE = 64
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [47:0] i_dest_address,
  input  logic [47:0] i_src_address,
  input  logic [15:0] i_eth_type,
  input  logic [15:0] i_payload_length,
  input  logic [7:0]  i_payload [PAYLOAD_LENGTH],
  input  logic [7:0]  i_interrupt,
  output logic [63:0] o_mii_data,
  output logic [7:0]  o_mii_valid
);

  localparam int unsigned L_CAP    = (PAYLOAD_LENGTH < PAYLOAD_MAX_SIZE) ? PAYLOAD_LENGTH : PAYLOAD_MAX_SIZE;
  localparam int unsigned MIN_PAY  = 46;
  localparam int unsigned BODY_MAX = 14 + ((L_CAP > MIN_PAY) ? L_CAP : MIN_PAY);
  localparam int unsigned IDX_W    = $clog2(BODY_MAX);

  localparam logic [63:0] IDLE_WORD = {8{8'h07}};
  localparam logic [63:0] PREAMBLE  = 64'hD555555555555555;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_IFG  = 2'd2;

  logic [1:0]  state_q;
  logic [7:0]  frame_q [BODY_MAX];
  logic [7:0]  body_len_q;
  logic [7:0]  pos_q;
  logic [31:0] crc_q;
  logic        ifg_cnt_q;

  logic [15:0] len_eff;
  logic [15:0] pay_span;
  logic [7:0]  body_len_d;
  logic [7:0]  frame_d [BODY_MAX];

  logic [7:0]  stream_len;
  logic [7:0]  b;
  logic [1:0]  fk;
  logic [31:0] crc_nxt;
  logic [31:0] fcs;
  logic [63:0] word_data;
  logic [7:0]  word_valid;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Frame body image (header + payload + zero pad) built from the live inputs
  always_comb begin
    len_eff    = (i_payload_length > 16'(L_CAP)) ? 16'(L_CAP) : i_payload_length;
    pay_span   = (len_eff > 16'(MIN_PAY)) ? len_eff : 16'(MIN_PAY);
    body_len_d = 8'(pay_span + 16'd14);
    for (int unsigned i = 0; i < 6; i++) begin
      frame_d[i]     = i_dest_address[8*(5-i) +: 8];
      frame_d[6 + i] = i_src_address[8*(5-i) +: 8];
    end
    frame_d[12] = i_eth_type[15:8];
    frame_d[13] = i_eth_type[7:0];
    for (int unsigned p = 0; p < BODY_MAX - 14; p++) begin
      frame_d[14 + p] = (p < PAYLOAD_LENGTH && p < 32'(len_eff)) ? i_payload[p] : 8'h00;
    end
  end

  // Lanes are walked in wire order so FCS lanes see the CRC of every body byte before them
  always_comb begin
    stream_len = body_len_q + 8'd4;
    crc_nxt    = crc_q;
    fcs        = '0;
    fk         = '0;
    b          = '0;
    word_data  = IDLE_WORD;
    word_valid = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      b = pos_q + 8'(n);
      if (b < body_len_q) begin
        word_data[8*n +: 8] = frame_q[b[IDX_W-1:0]];
        crc_nxt             = crc_byte(crc_nxt, frame_q[b[IDX_W-1:0]]);
        word_valid[n]       = 1'b1;
      end else if (b < stream_len) begin
        fcs                 = ~crc_nxt;
        fk                  = 2'(b - body_len_q);
        word_data[8*n +: 8] = fcs[{fk, 3'b000} +: 8];
        word_valid[n]       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      o_mii_data  <= IDLE_WORD;
      o_mii_valid <= '0;
      body_len_q  <= '0;
      pos_q       <= '0;
      crc_q       <= '1;
      ifg_cnt_q   <= 1'b0;
      for (int unsigned i = 0; i < BODY_MAX; i++) begin
        frame_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start && i_interrupt == '0) begin
            frame_q     <= frame_d;
            body_len_q  <= body_len_d;
            pos_q       <= '0;
            crc_q       <= '1;
            o_mii_data  <= PREAMBLE;
            o_mii_valid <= '1;
            state_q     <= ST_SEND;
          end else begin
            o_mii_data  <= IDLE_WORD;
            o_mii_valid <= '0;
          end
        end
        ST_SEND: begin
          if (i_interrupt != '0) begin
            o_mii_data  <= IDLE_WORD;
            o_mii_valid <= '0;
            ifg_cnt_q   <= 1'b0;
            state_q     <= ST_IFG;
          end else begin
            o_mii_data  <= word_data;
            o_mii_valid <= word_valid;
            pos_q       <= pos_q + 8'd8;
            crc_q       <= crc_nxt;
            if (pos_q + 8'd8 >= stream_len) begin
              ifg_cnt_q <= 1'b0;
              state_q   <= ST_IFG;
            end
          end
        end
        ST_IFG: begin
          o_mii_data  <= IDLE_WORD;
          o_mii_valid <= '0;
          if (ifg_cnt_q) begin
            state_q <= ST_IDLE;
          end else begin
            ifg_cnt_q <= 1'b1;
          end
        end
        default: begin
          o_mii_data  <= IDLE_WORD;
          o_mii_valid <= '0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_mii_top.sv
// Directed bench for mac_mii_top: table of frame vectors checked word-by-word against a
// byte-stream reference model, plus back-to-back, interrupt and mid-frame reset sequences.
module tb_mac_mii_top;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;

  logic        clk;
  logic        i_rst_n;
  logic        i_start;
  logic [47:0] i_dest_address;
  logic [47:0] i_src_address;
  logic [15:0] i_eth_type;
  logic [15:0] i_payload_length;
  logic [7:0]  pay [50];
  logic [7:0]  i_interrupt;
  logic [63:0] o_mii_data;
  logic [7:0]  o_mii_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [63:0] exp_w [16];
  logic [7:0]  exp_v [16];
  int unsigned exp_n;

  typedef struct {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    logic [15:0] len;
    int unsigned words;
    logic [7:0]  last_v;
  } vec_t;

  vec_t        vecs [7];
  logic [63:0] hw [3];

  mac_mii_top #(
    .PAYLOAD_LENGTH   (50),
    .PAYLOAD_MAX_SIZE (64)
  ) dut (
    .clk              (clk),
    .i_rst_n          (i_rst_n),
    .i_start          (i_start),
    .i_dest_address   (i_dest_address),
    .i_src_address    (i_src_address),
    .i_eth_type       (i_eth_type),
    .i_payload_length (i_payload_length),
    .i_payload        (pay),
    .i_interrupt      (i_interrupt),
    .o_mii_data       (o_mii_data),
    .o_mii_valid      (o_mii_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] ad, input logic [7:0] av,
                       input logic [63:0] ed, input logic [7:0] ev);
    checks++;
    if (ad !== ed || av !== ev) begin
      errors++;
      $display("FAIL %s: got data=%h valid=%h, expected data=%h valid=%h", name, ad, av, ed, ev);
    end
  endtask

  task automatic fill_payload();
    logic [63:0] head;
    head = 64'hBBAADEADBEEF1234;
    for (int i = 0; i < 50; i++) begin
      if (i < 8) pay[i] = head[63 - 8*i -: 8];
      else       pay[i] = 8'(i * 13 + 5);
    end
  endtask

  // Reference: flat wire byte stream (preamble..FCS) sliced into 8-byte words
  task automatic build_exp(input logic [47:0] d, input logic [47:0] s,
                           input logic [15:0] t, input logic [15:0] len);
    logic [7:0]  bytes [$];
    int unsigned l;
    int unsigned idx;
    logic [31:0] c;
    bytes = {};
    for (int i = 0; i < 7; i++) bytes.push_back(8'h55);
    bytes.push_back(8'hD5);
    for (int i = 0; i < 6; i++) bytes.push_back(d[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) bytes.push_back(s[47 - 8*i -: 8]);
    bytes.push_back(t[15:8]);
    bytes.push_back(t[7:0]);
    l = (len > 16'd50) ? 50 : int'(len);
    for (int i = 0; i < int'(l); i++) bytes.push_back(pay[i]);
    for (int i = int'(l); i < 46; i++) bytes.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int k = 8; k < bytes.size(); k++) begin
      c = c ^ {24'h0, bytes[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    bytes.push_back(c[7:0]);
    bytes.push_back(c[15:8]);
    bytes.push_back(c[23:16]);
    bytes.push_back(c[31:24]);
    exp_n = (bytes.size() + 7) / 8;
    for (int w = 0; w < 16; w++) begin
      exp_w[w] = IDLE_W;
      exp_v[w] = 8'h00;
      for (int n = 0; n < 8; n++) begin
        idx = 8*w + n;
        if (idx < bytes.size()) begin
          exp_w[w][8*n +: 8] = bytes[idx];
          exp_v[w][n]        = 1'b1;
        end
      end
    end
  endtask

  task automatic set_inputs(input vec_t v);
    i_dest_address   = v.dest;
    i_src_address    = v.src;
    i_eth_type       = v.etype;
    i_payload_length = v.len;
  endtask

  initial begin
    logic [7:0] last_v;

    vecs[0] = '{48'hFFFFFFFFFFFF, 48'h123456789ABC, 16'h0800, 16'd8,   9,  8'hFF};
    vecs[1] = '{48'h020000000001, 48'h0A1B2C3D4E5F, 16'h88B5, 16'd50,  10, 8'h0F};
    vecs[2] = '{48'h020000000001, 48'h0A1B2C3D4E5F, 16'h88B5, 16'd200, 10, 8'h0F};
    vecs[3] = '{48'h665544332211, 48'h00AABBCCDDEE, 16'h86DD, 16'd0,   9,  8'hFF};
    vecs[4] = '{48'h665544332211, 48'h00AABBCCDDEE, 16'h86DD, 16'd46,  9,  8'hFF};
    vecs[5] = '{48'h665544332211, 48'h00AABBCCDDEE, 16'h86DD, 16'd47,  10, 8'h01};
    vecs[6] = '{48'h665544332211, 48'h00AABBCCDDEE, 16'h86DD, 16'd49,  10, 8'h07};
    hw[0] = 64'hD555555555555555;
    hw[1] = 64'h3412FFFFFFFFFFFF;
    hw[2] = 64'hAABB0008BC9A7856;

    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_interrupt = 8'h00;
    set_inputs(vecs[0]);
    fill_payload();

    repeat (2) @(negedge clk);
    check("reset_held", o_mii_data, o_mii_valid, IDLE_W, 8'h00);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_released", o_mii_data, o_mii_valid, IDLE_W, 8'h00);

    // Table-driven single frames; inputs are scrambled after capture
    for (int i = 0; i < 7; i++) begin
      fill_payload();
      set_inputs(vecs[i]);
      build_exp(vecs[i].dest, vecs[i].src, vecs[i].etype, vecs[i].len);
      i_start = 1'b1;
      last_v  = 8'h00;
      for (int w = 0; w < int'(vecs[i].words); w++) begin
        @(negedge clk);
        if (w == 0) begin
          i_start          = 1'b0;
          i_dest_address   = 48'h0;
          i_src_address    = 48'h0;
          i_eth_type       = 16'hFFFF;
          i_payload_length = 16'd3;
          pay[0]           = 8'h00;
          pay[20]          = 8'h00;
        end
        check($sformatf("v%0d_word%0d", i, w), o_mii_data, o_mii_valid, exp_w[w], exp_v[w]);
        if (i == 0 && w < 3)
          check($sformatf("v0_hand_word%0d", w), o_mii_data, o_mii_valid, hw[w], 8'hFF);
        last_v = o_mii_valid;
      end
      checks++;
      if (last_v !== vecs[i].last_v) begin
        errors++;
        $display("FAIL v%0d_last_valid: got %h expected %h", i, last_v, vecs[i].last_v);
      end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check($sformatf("v%0d_idle%0d", i, k), o_mii_data, o_mii_valid, IDLE_W, 8'h00);
      end
    end

    // Held start: 9-word frames separated by exactly 2 idle words
    fill_payload();
    set_inputs(vecs[0]);
    build_exp(vecs[0].dest, vecs[0].src, vecs[0].etype, vecs[0].len);
    i_start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k % 11 < 9)
        check($sformatf("b2b_cyc%0d", k), o_mii_data, o_mii_valid, exp_w[k % 11], exp_v[k % 11]);
      else
        check($sformatf("b2b_cyc%0d", k), o_mii_data, o_mii_valid, IDLE_W, 8'h00);
    end
    i_start = 1'b0;
    repeat (12) @(negedge clk);
    check("b2b_drained", o_mii_data, o_mii_valid, IDLE_W, 8'h00);

    // Interrupt during word 4, with start held to verify starts are blocked
    i_start = 1'b1;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      if (w == 0) i_start = 1'b0;
      check($sformatf("irq_word%0d", w), o_mii_data, o_mii_valid, exp_w[w], exp_v[w]);
    end
    i_interrupt = 8'h01;
    i_start     = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("irq_idle%0d", k), o_mii_data, o_mii_valid, IDLE_W, 8'h00);
    end
    i_interrupt = 8'h00;
    i_start     = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-frame: asynchronous idle, no continuation after release
    set_inputs(vecs[1]);
    build_exp(vecs[1].dest, vecs[1].src, vecs[1].etype, vecs[1].len);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("rst_mid_word0", o_mii_data, o_mii_valid, exp_w[0], exp_v[0]);
    repeat (2) @(negedge clk);
    check("rst_mid_word2", o_mii_data, o_mii_valid, exp_w[2], exp_v[2]);
    #1 i_rst_n = 1'b0;
    #1 check("rst_mid_async", o_mii_data, o_mii_valid, IDLE_W, 8'h00);
    @(negedge clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("rst_after%0d", k), o_mii_data, o_mii_valid, IDLE_W, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
